// File: rtl/serial_add_sub_if.sv
// Start/busy/done request-and-result bundle for serial_add_sub.
// The master issues operands; the slave returns the result and status.
interface serial_add_sub_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic             Op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, Op, a, b,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, Op, a, b,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock, LSB slice first.
// Optional: define SERIAL_ADDSUB_SAT_EN to saturate sum on signed overflow.
module serial_add_sub #(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   serial_add_sub_if.slave bus
);
   localparam int unsigned BPC   = BITS_PER_CYCLE;
   localparam int unsigned SW    = BPC + 1;
   localparam int unsigned N     = WIDTH / BPC;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

   generate
      if ((WIDTH < 2) || (BPC == 0) || ((WIDTH % BPC) != 0)) begin : g_bad_cfg
         $error("serial_add_sub: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   logic [BPC-1:0]     a_sl_c;
   logic [BPC-1:0]     b_sl_c;
   logic [SW-1:0]      slice_c;
   logic [WIDTH-1:0]   res_ins_c;
   logic               msb_cin_c;
   logic               ovf_c;
   logic [WIDTH-1:0]   fin_sum_c;

`ifdef SERIAL_ADDSUB_SAT_EN
   logic               a_msb_q, a_msb_d;
   logic [WIDTH-1:0]   sat_c;
`endif

   // Current slice sits in the low bits of the shifting operand registers
   always_comb begin
      a_sl_c    = a_q[BPC-1:0];
      b_sl_c    = b_q[BPC-1:0];
      slice_c   = SW'(a_sl_c) + SW'(b_sl_c) + SW'(carry_q);
      res_ins_c = (res_q >> BPC) | (WIDTH'(slice_c[BPC-1:0]) << (WIDTH - BPC));
      // On the last slice its top bit is the MSB, so the carry into it is recoverable
      msb_cin_c = slice_c[BPC-1] ^ a_sl_c[BPC-1] ^ b_sl_c[BPC-1];
      ovf_c     = slice_c[BPC] ^ msb_cin_c;
`ifdef SERIAL_ADDSUB_SAT_EN
      sat_c     = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      fin_sum_c = ovf_c ? sat_c : res_ins_c;
`else
      fin_sum_c = res_ins_c;
`endif
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
`ifdef SERIAL_ADDSUB_SAT_EN
      a_msb_d = a_msb_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d = S_RUN;
               a_d     = bus.a;
               b_d     = bus.b ^ {WIDTH{bus.Op}};
               carry_d = bus.Op;
               cnt_d   = '0;
               busy_d  = 1'b1;
`ifdef SERIAL_ADDSUB_SAT_EN
               a_msb_d = bus.a[WIDTH-1];
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            a_d     = a_q >> BPC;
            b_d     = b_q >> BPC;
            carry_d = slice_c[BPC];
            res_d   = res_ins_c;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N - 1)) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               sum_d   = fin_sum_c;
               cout_d  = slice_c[BPC];
               ovf_d   = ovf_c;
            end else begin
               busy_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_SAT_EN
         a_msb_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
`ifdef SERIAL_ADDSUB_SAT_EN
         a_msb_q <= a_msb_d;
`endif
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;

endmodule
